// File: rtl/seq_ctrl_if.sv
// Instruction-memory fetch channel between the EyeArch sequencer and its
// instruction store: request/address out, acknowledge/data back.
interface seq_ctrl_if #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the EyeArch core: owns PC,
// IR, retired-instruction count, halt handling and the fetch-timeout fault.
module seq_ctrl #(
    parameter int PC_W          = 8,
    parameter int INST_W        = 16,
    parameter int RET_W         = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt_req,
    seq_ctrl_if.master        imem,
    output logic [INST_W-1:0] ir,
    output logic [5:0]        opcode,
    input  logic [1:0]        inst_type,
    input  logic              cu_reg_write,
    output logic              alu_go,
    output logic              rf_we,
    output logic [PC_W-1:0]   pc,
    output logic [RET_W-1:0]  retired,
    output logic [2:0]        state,
    output logic              fault
);

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t           cur_st;
    state_t           nxt_st;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_nxt;
    logic             halt_pend;
    logic             halt_pend_nxt;
    logic             ir_load;
    logic             retire;
    logic             boundary;

    function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        nxt_st        = cur_st;
        to_cnt_nxt    = to_cnt;
        halt_pend_nxt = halt_pend;
        ir_load       = 1'b0;
        retire        = 1'b0;
        boundary      = 1'b0;

        case (cur_st)
            S_IDLE: begin
                if (run) nxt_st = S_FETCH;
            end
            S_FETCH: begin
                // run is deliberately not looked at: a started fetch always completes or times out
                if (imem.imem_ack) begin
                    ir_load    = 1'b1;
                    to_cnt_nxt = '0;
                    nxt_st     = S_DECODE;
                end else if (to_cnt == CNT_LAST) begin
                    to_cnt_nxt = '0;
                    nxt_st     = S_FAULT;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            S_DECODE: begin
                case (inst_type)
                    2'b00: begin
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end
                    2'b01:   nxt_st = S_EXEC;
                    2'b10:   nxt_st = S_WB;
                    default: nxt_st = S_FAULT;
                endcase
            end
            S_EXEC: nxt_st = S_WB;
            S_WB: begin
                retire   = 1'b1;
                boundary = 1'b1;
            end
            S_HALT: begin
                if (!run) nxt_st = S_IDLE;
            end
            S_FAULT: nxt_st = S_FAULT;
            default: nxt_st = S_FAULT;
        endcase

        // A pending or same-cycle halt wins over run at the instruction boundary
        if (boundary) begin
            if (halt_pend || halt_req) begin
                nxt_st        = S_HALT;
                halt_pend_nxt = 1'b0;
            end else if (!run) begin
                nxt_st = S_IDLE;
            end else begin
                nxt_st = S_FETCH;
            end
        end else if (halt_req && (cur_st != S_HALT) && (cur_st != S_FAULT)) begin
            halt_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= S_IDLE;
            to_cnt    <= '0;
            halt_pend <= 1'b0;
            ir        <= '0;
            pc        <= '0;
            retired   <= '0;
        end else begin
            cur_st    <= nxt_st;
            to_cnt    <= to_cnt_nxt;
            halt_pend <= halt_pend_nxt;
            if (ir_load) ir <= imem.imem_rdata;
            if (retire) begin
                pc      <= pc + 1'b1;
                retired <= sat_inc(retired);
            end
        end
    end

    // Strobes decode the state register directly, so reset clears them at once
    assign state          = cur_st;
    assign imem.imem_req  = (cur_st == S_FETCH);
    assign imem.imem_addr = pc;
    assign alu_go         = (cur_st == S_EXEC);
    assign rf_we          = (cur_st == S_WB) && cu_reg_write;
    assign fault          = (cur_st == S_FAULT);
    assign opcode         = ir[INST_W-1 -: 6];

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: instruction-memory model, small control-unit
// model, and one task per scenario with hand-computed expectations.
module tb_seq_ctrl;
    localparam int PC_W   = 8;
    localparam int INST_W = 16;
    localparam int RET_W  = 16;
    localparam int FT     = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic              halt_req;
    logic [1:0]        inst_type;
    logic              cu_reg_write;
    logic [INST_W-1:0] ir;
    logic [5:0]        opcode;
    logic              alu_go;
    logic              rf_we;
    logic [PC_W-1:0]   pc;
    logic [RET_W-1:0]  retired;
    logic [2:0]        state;
    logic              fault;
    logic [INST_W-1:0] mem [256];
    logic              ack_en;
    logic              force_ack;
    int                checks = 0;
    int                errors = 0;

    seq_ctrl_if #(.PC_W(PC_W), .INST_W(INST_W)) imem ();

    assign imem.imem_ack   = force_ack | (ack_en & imem.imem_req);
    assign imem.imem_rdata = mem[imem.imem_addr];

    // Control unit: 00 NOP, 01 ADD (writes), 02 CMP-like ALU (no write), 0E LDIM, rest illegal
    always_comb begin
        inst_type    = 2'b11;
        cu_reg_write = 1'b0;
        case (opcode)
            6'h00: inst_type = 2'b00;
            6'h01: begin inst_type = 2'b01; cu_reg_write = 1'b1; end
            6'h02: inst_type = 2'b01;
            6'h0E: begin inst_type = 2'b10; cu_reg_write = 1'b1; end
            default: ;
        endcase
    end

    always #5 clk = ~clk;

    seq_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .RET_W(RET_W), .FETCH_TIMEOUT(FT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .halt_req     (halt_req),
        .imem         (imem),
        .ir           (ir),
        .opcode       (opcode),
        .inst_type    (inst_type),
        .cu_reg_write (cu_reg_write),
        .alu_go       (alu_go),
        .rf_we        (rf_we),
        .pc           (pc),
        .retired      (retired),
        .state        (state),
        .fault        (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        halt_req  = 1'b0;
        ack_en    = 1'b1;
        force_ack = 1'b0;
        clear_mem();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; run = 1'b0; halt_req = 1'b0; ack_en = 1'b1; force_ack = 1'b0;
        clear_mem();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected 0000", ir); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        checks++; if ({fault, alu_go, rf_we, imem.imem_req} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {fault, alu_go, rf_we, imem.imem_req}); end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (state !== 3'd0 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL idle_hold: got state %0d req %b expected 0 0", state, imem.imem_req); end
    endtask

    task automatic test_alu();
        do_reset();
        mem[0] = 16'h0400;
        run = 1'b1;
        tick(); // cycle 1
        checks++; if (state !== 3'd1 || imem.imem_req !== 1'b1 || imem.imem_addr !== 8'h00) begin errors++; $display("FAIL alu_fetch: got state %0d req %b addr %h expected 1 1 00", state, imem.imem_req, imem.imem_addr); end
        tick(); // cycle 2
        checks++; if (state !== 3'd2 || ir !== 16'h0400 || opcode !== 6'h01) begin errors++; $display("FAIL alu_decode: got state %0d ir %h op %h expected 2 0400 01", state, ir, opcode); end
        tick(); // cycle 3
        checks++; if (alu_go !== 1'b1 || rf_we !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL alu_exec: got alu_go %b rf_we %b state %0d expected 1 0 3", alu_go, rf_we, state); end
        tick(); // cycle 4
        checks++; if (rf_we !== 1'b1 || alu_go !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL alu_wb: got rf_we %b alu_go %b pc %h expected 1 0 00", rf_we, alu_go, pc); end
        tick(); // cycle 5
        checks++; if (state !== 3'd1 || pc !== 8'h01 || retired !== 16'd1) begin errors++; $display("FAIL alu_next_fetch: got state %0d pc %h retired %0d expected 1 01 1", state, pc, retired); end
        run = 1'b0;
        tick();
        tick();
        checks++; if (state !== 3'd0 || pc !== 8'h02 || retired !== 16'd2) begin errors++; $display("FAIL alu_to_idle: got state %0d pc %h retired %0d expected 0 02 2", state, pc, retired); end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        mem[1] = 16'h0400;
        run = 1'b1;
        repeat (5) tick();
        checks++; if (alu_go !== 1'b1 || pc !== 8'h01 || retired !== 16'd1) begin errors++; $display("FAIL pre_reset_exec: got alu_go %b pc %h retired %0d expected 1 01 1", alu_go, pc, retired); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (alu_go !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL async_reset_strobe: got alu_go %b state %0d expected 0 0", alu_go, state); end
        checks++; if (pc !== 8'h00 || ir !== 16'h0000 || retired !== 16'd0 || fault !== 1'b0) begin errors++; $display("FAIL async_reset_regs: got pc %h ir %h retired %0d fault %b expected 00 0000 0 0", pc, ir, retired, fault); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_ldim_nop();
        do_reset();
        mem[0] = 16'h3800;
        mem[1] = 16'h0000;
        mem[2] = 16'h0800;
        run = 1'b1;
        tick(); // FETCH
        tick(); // DECODE
        checks++; if (opcode !== 6'h0E || alu_go !== 1'b0) begin errors++; $display("FAIL ldim_decode: got op %h alu_go %b expected 0e 0", opcode, alu_go); end
        tick(); // WB at cycle 3
        checks++; if (state !== 3'd4 || rf_we !== 1'b1 || alu_go !== 1'b0) begin errors++; $display("FAIL ldim_wb: got state %0d rf_we %b alu_go %b expected 4 1 0", state, rf_we, alu_go); end
        tick(); // FETCH of NOP
        checks++; if (state !== 3'd1 || pc !== 8'h01 || retired !== 16'd1) begin errors++; $display("FAIL ldim_retire: got state %0d pc %h retired %0d expected 1 01 1", state, pc, retired); end
        tick(); // DECODE NOP
        checks++; if (state !== 3'd2 || rf_we !== 1'b0 || alu_go !== 1'b0) begin errors++; $display("FAIL nop_decode: got state %0d rf_we %b alu_go %b expected 2 0 0", state, rf_we, alu_go); end
        tick(); // FETCH again after 2 cycles
        checks++; if (state !== 3'd1 || pc !== 8'h02 || retired !== 16'd2) begin errors++; $display("FAIL nop_two_cycle: got state %0d pc %h retired %0d expected 1 02 2", state, pc, retired); end
        tick(); // DECODE ALU no-write
        tick(); // EXEC
        tick(); // WB
        checks++; if (state !== 3'd4 || rf_we !== 1'b0) begin errors++; $display("FAIL wb_gated: got state %0d rf_we %b expected 4 0", state, rf_we); end
        tick();
        checks++; if (pc !== 8'h03 || retired !== 16'd3) begin errors++; $display("FAIL gated_retire: got pc %h retired %0d expected 03 3", pc, retired); end
        run = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        ack_en = 1'b0;
        run = 1'b1;
        repeat (5) tick();
        run = 1'b0;
        repeat (10) tick(); // 15th FETCH cycle
        checks++; if (state !== 3'd1 || imem.imem_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL timeout_last_fetch: got state %0d req %b fault %b expected 1 1 0", state, imem.imem_req, fault); end
        tick();
        checks++; if (state !== 3'd6 || fault !== 1'b1 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL timeout_fault: got state %0d fault %b req %b expected 6 1 0", state, fault, imem.imem_req); end
        mem[0] = 16'h0400;
        force_ack = 1'b1;
        run = 1'b1;
        repeat (3) tick();
        checks++; if (state !== 3'd6 || ir !== 16'h0000 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got state %0d ir %h fault %b expected 6 0000 1", state, ir, fault); end
        force_ack = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        mem[0] = 16'h0400;
        run = 1'b1;
        tick(); // FETCH
        tick(); // DECODE
        tick(); // EXEC
        halt_req = 1'b1;
        tick(); // WB
        halt_req = 1'b0;
        checks++; if (state !== 3'd4 || rf_we !== 1'b1) begin errors++; $display("FAIL halt_wb: got state %0d rf_we %b expected 4 1", state, rf_we); end
        tick();
        checks++; if (state !== 3'd5 || pc !== 8'h01 || retired !== 16'd1 || imem.imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got state %0d pc %h retired %0d req %b expected 5 01 1 0", state, pc, retired, imem.imem_req); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL halt_hold: got state %0d expected 5", state); end
        run = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL halt_exit: got state %0d expected 0", state); end
        run = 1'b1;
        tick(); // FETCH of NOP at 1
        tick(); // DECODE
        tick();
        checks++; if (state !== 3'd1 || pc !== 8'h02) begin errors++; $display("FAIL halt_req_ignored: got state %0d pc %h expected 1 02", state, pc); end
        run = 1'b0;
    endtask

    task automatic test_wrap_illegal();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (pc == 8'hFF && state == 3'd1) break;
            tick();
        end
        checks++; if (pc !== 8'hFF || state !== 3'd1 || retired !== 16'd255) begin errors++; $display("FAIL reach_ff: got pc %h state %0d retired %0d expected ff 1 255", pc, state, retired); end
        mem[0] = 16'hFC00;
        tick(); // DECODE NOP at FF
        tick();
        checks++; if (pc !== 8'h00 || retired !== 16'd256 || state !== 3'd1) begin errors++; $display("FAIL pc_wrap: got pc %h retired %0d state %0d expected 00 256 1", pc, retired, state); end
        tick(); // DECODE illegal
        checks++; if (opcode !== 6'h3F || state !== 3'd2) begin errors++; $display("FAIL illegal_decode: got op %h state %0d expected 3f 2", opcode, state); end
        tick();
        checks++; if (state !== 3'd6 || fault !== 1'b1 || pc !== 8'h00 || retired !== 16'd256) begin errors++; $display("FAIL illegal_fault: got state %0d fault %b pc %h retired %0d expected 6 1 00 256", state, fault, pc, retired); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_reset_mid_exec();
        test_ldim_nop();
        test_timeout();
        test_halt();
        test_wrap_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the EyeArch core.
- Fetches instruction words over a req/ack instruction-memory handshake and holds them in the IR.
- Presents the opcode to the combinational control unit and uses its decoded class and write-enable to step through FETCH/DECODE/EXEC/WB.
- Owns the PC, a retired-instruction counter, halt handling and a fetch-timeout fault.

Parameters:
- PC_W, 8, width of program counter / instruction address.
- INST_W, 16, instruction word width; opcode = ir[INST_W-1 -: 6].
- RET_W, 16, width of retired-instruction counter.
- FETCH_TIMEOUT, 15, max cycles a fetch may wait for imem_ack before fault (must be >= 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; enables instruction execution.
- halt_req  in  1  single-cycle or level halt request, honoured at instruction boundary.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  INST_W  fetched instruction.
- ir  out  INST_W  instruction register.
- opcode  out  6  ir[INST_W-1 -: 6], to control unit.
- inst_type  in  2  from control unit: 00 NOP, 01 ALU, 10 LDIM, 11 illegal.
- cu_reg_write  in  1  from control unit.
- alu_go  out  1  one-cycle ALU execute strobe.
- rf_we  out  1  gated register-file write enable.
- pc  out  PC_W  program counter.
- retired  out  RET_W  retired-instruction count.
- state  out  3  current state encoding.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (async, any time, incl. mid-instruction): state=IDLE, pc=0, ir=0, retired=0, timeout counter=0, halt_pend=0, fault=0. All strobes (imem_req, alu_go, rf_we) = 0 immediately.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, FAULT=6. Value 7 is unreachable; if entered, go to FAULT.
- IDLE: run=1 -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: ir<=imem_rdata, timeout counter cleared, -> DECODE.
  - Without ack: counter increments. When counter==FETCH_TIMEOUT-1 and still no ack -> FAULT.
  - run dropping during FETCH is ignored.
- DECODE: one cycle; inst_type is sampled from the control unit, which is driven by opcode(ir).
  - 00 NOP: pc<=pc+1, retired+1, boundary.
  - 01: -> EXEC.
  - 10: -> WB.
  - 11: -> FAULT; pc and retired are unchanged.
- EXEC: alu_go=1 for exactly this cycle, -> WB.
- WB:
  - rf_we=cu_reg_write for exactly this cycle.
  - pc<=pc+1, retired+1, boundary.
- Boundary rule (leaving DECODE-NOP or WB), in priority order:
  - halt_pend or halt_req this cycle -> HALT, and halt_pend is cleared.
  - else run=0 -> IDLE.
  - else -> FETCH.
- halt_pend is set by halt_req in any non-boundary cycle.
- HALT: all strobes 0. Exits to IDLE when run=0. A halt_req while in HALT is ignored.
- FAULT: fault=1, all strobes 0; only rst_n clears it.
- pc wraps modulo 2^PC_W (max -> 0).
- retired saturates at all-ones.
- imem_ack outside FETCH is ignored; ir is held.
- Latency with ack in the first FETCH cycle: ALU op 4 cycles, LDIM 3, NOP 2 (FETCH to next FETCH).
- Outputs are registered state decodes. alu_go and rf_we never assert in the same cycle.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC -> same-cycle alu_go=0, state=0, pc=0, ir=0, retired=0, fault=0.
- ALU op: run=1, imem_rdata=16'h0400 (ADD), ack in first FETCH cycle, cu gives 01/1 -> alu_go high in cycle 3, rf_we high in cycle 4, pc 0->1, retired=1, next FETCH at cycle 5.
- LDIM then NOP: opcode 001110 then 000000 -> LDIM has no alu_go and rf_we in cycle 3. NOP has rf_we=0 and takes 2 cycles. Final pc=2, retired=2.
- Fetch timeout: FETCH_TIMEOUT=15, never ack -> FAULT after 15 FETCH cycles, fault=1, imem_req=0. A later ack leaves state unchanged; only reset clears.
- Halt: pulse halt_req during EXEC -> instruction completes (rf_we pulse, pc+1), then state=HALT. Drop run -> IDLE.
- Wrap/illegal: preload pc=8'hFF via execution, run one NOP -> pc=0x00. Then inst_type=11 -> FAULT with pc=0x00 and retired unchanged.
